// File: rtl/mbist_march_ctrl_if.sv
// Single-port SRAM access bus between an MBIST controller (master) and one memory wrapper (slave).
interface mbist_march_ctrl_if #(
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned DATA_W = 8
) ();
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (output mem_en, mem_we, mem_addr, mem_wdata, input  mem_rdata);
    modport slave  (input  mem_en, mem_we, mem_addr, mem_wdata, output mem_rdata);
endinterface

// File: rtl/mbist_march_ctrl.sv
// March C- MBIST engine for one single-port SRAM: issues one op per cycle, checks reads
// after RD_LAT cycles and captures the first failing address and March element.
module mbist_march_ctrl #(
    parameter int unsigned ADDR_W       = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned RD_LAT       = 1,
    parameter bit          STOP_ON_FAIL = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [2:0]        fail_elem,
    mbist_march_ctrl_if.master mem
);
    localparam int unsigned ELEM_W = 3;
    localparam int unsigned DCNT_W = 2;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;
    localparam logic [DATA_W-1:0] DATA_ONES = '1;
    localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic              vld;
        logic [DATA_W-1:0] exp;
        logic [ADDR_W-1:0] addr;
        logic [ELEM_W-1:0] elem;
    } rd_tag_t;

    // Phase 0 of elements 1..5 is the read; element 0 is a lone write.
    function automatic logic op_is_rd(input logic [ELEM_W-1:0] e, input logic p);
        return (e != 3'd0) && !p;
    endfunction

    // Background selected by the op: 1 = all-ones, 0 = all-zeros.
    function automatic logic op_bg(input logic [ELEM_W-1:0] e, input logic p);
        return p ? (e == 3'd1 || e == 3'd3) : (e == 3'd2 || e == 3'd4);
    endfunction

    function automatic logic elem_down(input logic [ELEM_W-1:0] e);
        return (e == 3'd3) || (e == 3'd4);
    endfunction

    function automatic logic op_last_ph(input logic [ELEM_W-1:0] e, input logic p);
        return ((e == 3'd0) || (e == 3'd5)) ? 1'b1 : p;
    endfunction

    state_t            state_q;
    logic [ELEM_W-1:0] elem_q, elem_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ph_q, ph_d;
    logic              addr_end_c, last_op_c, cmp_fail_c, stop_c;
    logic [DCNT_W-1:0] dcnt_q;
    logic              busy_q, done_q, pass_q, fv_q;
    logic [ADDR_W-1:0] faddr_q;
    logic [ELEM_W-1:0] felem_q;
    logic              en_q, we_q;
    logic [DATA_W-1:0] wdata_q;
    rd_tag_t           pipe_q [RD_LAT];
    rd_tag_t           push_c;

    // Successor of the op currently on the bus; element change by full-width address compare.
    always_comb begin
        elem_d     = elem_q;
        addr_d     = addr_q;
        ph_d       = 1'b0;
        last_op_c  = 1'b0;
        addr_end_c = elem_down(elem_q) ? (addr_q == '0) : (addr_q == ADDR_LAST);
        if (!op_last_ph(elem_q, ph_q)) begin
            ph_d = 1'b1;
        end else if (!addr_end_c) begin
            addr_d = elem_down(elem_q) ? addr_q - ADDR_W'(1) : addr_q + ADDR_W'(1);
        end else if (elem_q == 3'd5) begin
            last_op_c = 1'b1;
        end else begin
            elem_d = elem_q + ELEM_W'(1);
            addr_d = elem_down(elem_d) ? ADDR_LAST : '0;
        end
    end

    always_comb begin
        push_c.vld  = en_q && !we_q;
        push_c.exp  = op_bg(elem_q, ph_q) ? DATA_ONES : '0;
        push_c.addr = addr_q;
        push_c.elem = elem_q;
        cmp_fail_c  = pipe_q[RD_LAT-1].vld && (mem.mem_rdata != pipe_q[RD_LAT-1].exp);
        stop_c      = STOP_ON_FAIL && cmp_fail_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            elem_q  <= '0;
            addr_q  <= '0;
            ph_q    <= 1'b0;
            dcnt_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b1;
            fv_q    <= 1'b0;
            faddr_q <= '0;
            felem_q <= '0;
            en_q    <= 1'b0;
            we_q    <= 1'b0;
            wdata_q <= '0;
            for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
        end else begin
            pipe_q[0] <= push_c;
            for (int unsigned i = 1; i < RD_LAT; i++) pipe_q[i] <= pipe_q[i-1];
            if (cmp_fail_c) begin
                pass_q <= 1'b0;
                if (!fv_q) begin
                    fv_q    <= 1'b1;
                    faddr_q <= pipe_q[RD_LAT-1].addr;
                    felem_q <= pipe_q[RD_LAT-1].elem;
                end
            end
            if (abort) begin
                state_q <= S_IDLE;
                busy_q  <= 1'b0;
                done_q  <= 1'b0;
                en_q    <= 1'b0;
                we_q    <= 1'b0;
                wdata_q <= '0;
                elem_q  <= '0;
                addr_q  <= '0;
                ph_q    <= 1'b0;
                for (int unsigned i = 0; i < RD_LAT; i++) pipe_q[i] <= '0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start) begin
                            state_q <= S_RUN;
                            busy_q  <= 1'b1;
                            done_q  <= 1'b0;
                            pass_q  <= 1'b1;
                            fv_q    <= 1'b0;
                            faddr_q <= '0;
                            felem_q <= '0;
                            elem_q  <= '0;
                            addr_q  <= '0;
                            ph_q    <= 1'b0;
                            en_q    <= 1'b1;
                            we_q    <= 1'b1;
                            wdata_q <= '0;
                        end
                    end
                    S_RUN: begin
                        if (last_op_c || stop_c) begin
                            state_q <= S_DRAIN;
                            dcnt_q  <= '0;
                            en_q    <= 1'b0;
                            we_q    <= 1'b0;
                            wdata_q <= '0;
                        end else begin
                            elem_q  <= elem_d;
                            addr_q  <= addr_d;
                            ph_q    <= ph_d;
                            en_q    <= 1'b1;
                            we_q    <= !op_is_rd(elem_d, ph_d);
                            wdata_q <= (!op_is_rd(elem_d, ph_d) && op_bg(elem_d, ph_d)) ? DATA_ONES : '0;
                        end
                    end
                    S_DRAIN: begin
                        if (dcnt_q == DCNT_LAST) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                        end else begin
                            dcnt_q <= dcnt_q + DCNT_W'(1);
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_valid    = fv_q;
    assign fail_addr     = faddr_q;
    assign fail_elem     = felem_q;
    assign mem.mem_en    = en_q;
    assign mem.mem_we    = we_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
endmodule

// File: tb/tb_mbist_march_ctrl.sv
// Bench for mbist_march_ctrl: three configurations, each with a RAM model that can hold one
// stuck-at fault; op stream checked against a queue of expected March C- ops.
module tb_mbist_march_ctrl;
    localparam int NDUT = 3;

    logic clk = 1'b0;
    logic rst_n;
    logic [NDUT-1:0] start, abort;
    logic [NDUT-1:0] busy_w, done_w, pass_w, fv_w, en_w, we_w;
    logic [3:0] faddr_w [NDUT];
    logic [2:0] felem_w [NDUT];
    logic [3:0] addr_w  [NDUT];
    logic [7:0] wdata_w [NDUT];
    logic [NDUT-1:0] flt_en;
    logic [3:0] flt_addr [NDUT];
    logic [7:0] flt_sa1  [NDUT];
    logic [7:0] flt_sa0  [NDUT];

    always #5 clk = ~clk;

    // dut0: 4-bit addr, RD_LAT 1; dut1: 3-bit addr, RD_LAT 3; dut2: 4-bit addr, RD_LAT 2, stop on fail
    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        localparam int AW  = (g == 1) ? 3 : 4;
        localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 2);
        localparam bit SOF = 1'(g == 2);

        mbist_march_ctrl_if #(.ADDR_W(AW), .DATA_W(8)) mif ();
        logic [AW-1:0] fa;
        logic [7:0] ram [1 << AW];
        logic [7:0] rq  [LAT];

        mbist_march_ctrl #(.ADDR_W(AW), .DATA_W(8), .RD_LAT(LAT), .STOP_ON_FAIL(SOF)) u_dut (
            .clk(clk), .rst_n(rst_n), .start(start[g]), .abort(abort[g]),
            .busy(busy_w[g]), .done(done_w[g]), .pass(pass_w[g]), .fail_valid(fv_w[g]),
            .fail_addr(fa), .fail_elem(felem_w[g]), .mem(mif)
        );

        assign faddr_w[g]    = 4'(fa);
        assign en_w[g]       = mif.mem_en;
        assign we_w[g]       = mif.mem_we;
        assign addr_w[g]     = 4'(mif.mem_addr);
        assign wdata_w[g]    = mif.mem_wdata;
        assign mif.mem_rdata = rq[LAT-1];

        // Non-read cycles return a marker so a misaligned compare cannot pass.
        always @(posedge clk) begin
            if (mif.mem_en && mif.mem_we) ram[mif.mem_addr] <= mif.mem_wdata;
            if (mif.mem_en && !mif.mem_we)
                rq[0] <= (flt_en[g] && flt_addr[g] == 4'(mif.mem_addr))
                         ? ((ram[mif.mem_addr] | flt_sa1[g]) & ~flt_sa0[g]) : ram[mif.mem_addr];
            else
                rq[0] <= 8'h5A;
            for (int i = 1; i < LAT; i++) rq[i] <= rq[i-1];
        end
    end

    typedef struct packed {
        logic       we;
        logic [3:0] addr;
        logic [7:0] wd;
    } op_t;

    typedef struct {
        int         dut;
        bit         fen;
        logic [3:0] fadr;
        logic [7:0] sa1;
        logic [7:0] sa0;
        int         ops;
        int         done_cyc;
        int         pass;
        int         fv;
        int         faddr;
        int         felem;
    } vec_t;

    vec_t vecs [7];
    op_t  exp_q [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic int dut_aw(input int d);
        return (d == 1) ? 3 : 4;
    endfunction

    task automatic push_op(input logic we, input int a, input logic [7:0] wd);
        op_t o;
        o.we = we; o.addr = 4'(a); o.wd = wd;
        exp_q.push_back(o);
    endtask

    task automatic push_ops(input int aw);
        int n;
        int a;
        n = 1 << aw;
        exp_q.delete();
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < n; k++) begin
                a = (e == 3 || e == 4) ? n - 1 - k : k;
                case (e)
                    0:       push_op(1'b1, a, 8'h00);
                    1, 3:    begin push_op(1'b0, a, 8'h00); push_op(1'b1, a, 8'hFF); end
                    2, 4:    begin push_op(1'b0, a, 8'h00); push_op(1'b1, a, 8'h00); end
                    default: push_op(1'b0, a, 8'h00);
                endcase
            end
        end
    endtask

    // Start pulse sampled at the edge closing cycle 0; returns #1 into cycle 1.
    task automatic kick(input int d);
        @(negedge clk);
        start[d] = 1'b1;
        @(posedge clk); #1;
        start[d] = 1'b0;
    endtask

    // Walks cycles 1..stop_at-1 (or until done), popping one expected op per mem_en cycle.
    task automatic monitor(input int d, input int stop_at, input int restart_at,
                           output int ops, output int last_en, output int done_cyc,
                           output int busy_bad);
        op_t o;
        ops = 0; last_en = 0; done_cyc = 0; busy_bad = 0;
        for (int cyc = 1; cyc < stop_at; cyc++) begin
            if (done_w[d]) begin
                done_cyc = cyc;
                break;
            end
            if (!busy_w[d]) busy_bad++;
            if (en_w[d]) begin
                ops++;
                last_en = cyc;
                if (exp_q.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL sb_underflow: op %0d at cycle %0d, expected none", ops, cyc);
                end else begin
                    o = exp_q.pop_front();
                    chk($sformatf("op%0d_dut%0d", ops, d),
                        int'({we_w[d], addr_w[d], wdata_w[d]}), int'({o.we, o.addr, o.wd}));
                end
            end
            start[d] = (cyc == restart_at);
            @(posedge clk); #1;
        end
        start[d] = 1'b0;
    endtask

    task automatic run_case(input int r, input int restart_at);
        int d, ops, last_en, done_cyc, busy_bad;
        d = vecs[r].dut;
        flt_en = '0;
        flt_en[d]   = vecs[r].fen;
        flt_addr[d] = vecs[r].fadr;
        flt_sa1[d]  = vecs[r].sa1;
        flt_sa0[d]  = vecs[r].sa0;
        push_ops(dut_aw(d));
        kick(d);
        monitor(d, 1000, restart_at, ops, last_en, done_cyc, busy_bad);
        chk($sformatf("r%0d_done_cycle", r), done_cyc, vecs[r].done_cyc);
        chk($sformatf("r%0d_op_count", r), ops, vecs[r].ops);
        chk($sformatf("r%0d_contiguous", r), last_en, ops);
        chk($sformatf("r%0d_busy_window", r), busy_bad, 0);
        chk($sformatf("r%0d_busy_at_done", r), int'(busy_w[d]), 0);
        chk($sformatf("r%0d_en_at_done", r), int'(en_w[d]), 0);
        chk($sformatf("r%0d_pass", r), int'(pass_w[d]), vecs[r].pass);
        chk($sformatf("r%0d_fail_valid", r), int'(fv_w[d]), vecs[r].fv);
        chk($sformatf("r%0d_fail_addr", r), int'(faddr_w[d]), vecs[r].faddr);
        chk($sformatf("r%0d_fail_elem", r), int'(felem_w[d]), vecs[r].felem);
        flt_en = '0;
    endtask

    initial begin
        int ops, last_en, done_cyc, busy_bad, cnt;
        rst_n = 1'b0; start = '0; abort = '0; flt_en = '0;
        for (int i = 0; i < NDUT; i++) begin
            flt_addr[i] = '0; flt_sa1[i] = '0; flt_sa0[i] = '0;
        end
        //          dut fen adr sa1    sa0    ops done pass fv fa fe
        vecs[0] = '{0, 0, 0,  8'h00, 8'h00, 160, 162, 1, 0, 0,  0};
        vecs[1] = '{0, 1, 5,  8'h01, 8'h00, 160, 162, 0, 1, 5,  1};
        vecs[2] = '{1, 0, 0,  8'h00, 8'h00, 80,  84,  1, 0, 0,  0};
        vecs[3] = '{2, 1, 2,  8'h00, 8'h80, 55,  58,  0, 1, 2,  2};
        vecs[4] = '{0, 1, 15, 8'h00, 8'h08, 160, 162, 0, 1, 15, 2};
        vecs[5] = '{1, 1, 0,  8'h40, 8'h00, 80,  84,  0, 1, 0,  1};
        vecs[6] = '{2, 0, 0,  8'h00, 8'h00, 160, 163, 1, 0, 0,  0};

        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) begin
            chk($sformatf("rst_busy%0d", d), int'(busy_w[d]), 0);
            chk($sformatf("rst_pass%0d", d), int'(pass_w[d]), 1);
            chk($sformatf("rst_en%0d", d),   int'(en_w[d]), 0);
        end
        @(negedge clk) rst_n = 1'b1;

        // Row 0 also re-pulses start at cycle 20 while busy.
        for (int r = 0; r < 7; r++) run_case(r, (r == 0) ? 20 : -1);

        // Abort during cycle 40, then a clean rerun.
        push_ops(4);
        kick(0);
        monitor(0, 40, -1, ops, last_en, done_cyc, busy_bad);
        chk("abort_pre_ops", ops, 39);
        abort[0] = 1'b1;
        @(posedge clk); #1;
        abort[0] = 1'b0;
        chk("abort_busy", int'(busy_w[0]), 0);
        chk("abort_done", int'(done_w[0]), 0);
        chk("abort_en",   int'(en_w[0]), 0);
        cnt = 0;
        repeat (10) begin
            @(posedge clk); #1;
            cnt += int'(en_w[0]) + int'(busy_w[0]);
        end
        chk("abort_quiet", cnt, 0);
        run_case(0, -1);

        // start and abort together from DONE: abort wins.
        @(negedge clk);
        start[0] = 1'b1; abort[0] = 1'b1;
        @(posedge clk); #1;
        start[0] = 1'b0; abort[0] = 1'b0;
        chk("sa_busy", int'(busy_w[0]), 0);
        chk("sa_done", int'(done_w[0]), 0);
        chk("sa_en",   int'(en_w[0]), 0);

        // Asynchronous reset during cycle 50.
        push_ops(4);
        kick(0);
        monitor(0, 50, -1, ops, last_en, done_cyc, busy_bad);
        chk("rst_pre_ops", ops, 49);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy",  int'(busy_w[0]), 0);
        chk("mrst_done",  int'(done_w[0]), 0);
        chk("mrst_pass",  int'(pass_w[0]), 1);
        chk("mrst_fv",    int'(fv_w[0]), 0);
        chk("mrst_faddr", int'(faddr_w[0]), 0);
        chk("mrst_felem", int'(felem_w[0]), 0);
        chk("mrst_en",    int'(en_w[0]), 0);
        chk("mrst_we",    int'(we_w[0]), 0);
        chk("mrst_addr",  int'(addr_w[0]), 0);
        chk("mrst_wdata", int'(wdata_w[0]), 0);
        cnt = 0;
        repeat (3) begin
            @(posedge clk); #1;
            cnt += int'(en_w[0]);
        end
        chk("mrst_quiet", cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        run_case(0, -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
